// File: rtl/pfu_pkg.sv
// pfu_pkg: types shared by the rv32i prefetch unit and its fetch buffer.
// The SOFID_* macros normally come from riscv_defs.v; the guarded fallbacks keep this slice self-contained.
`ifndef SOFID_RANGE
`define SOFID_RANGE 1:0
`endif
`ifndef SOFID_1ST
`define SOFID_1ST 2'b01
`endif
`ifndef SOFID_RUN
`define SOFID_RUN 2'b00
`endif

package pfu_pkg;

   typedef logic [`SOFID_RANGE] sofid_t;

   localparam sofid_t SOFID_FIRST = `SOFID_1ST;
   localparam sofid_t SOFID_NEXT  = `SOFID_RUN;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic        ferr;
      sofid_t      sofid;
   } fetch_entry_t;

endpackage

// File: rtl/pfu_fifo.sv
// pfu_fifo: DEPTH-entry fetch buffer with synchronous flush, count and full/empty flags.
module pfu_fifo
   import pfu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   en_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  fetch_entry_t           din_i,
   input  logic                   pop_i,
   output fetch_entry_t           dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_pop;

   assign do_pop  = pop_i & ~empty_o;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_FULL);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (en_i) begin
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_i, do_pop})
               2'b10:   count_q <= count_q + CNT_ONE;
               2'b01:   count_q <= count_q - CNT_ONE;
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // NOTE: storage has no reset; entries are only read once the count says they were written.
   always_ff @(posedge clk_i) begin
      if (en_i && push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/pfu.sv
// pfu: rv32i prefetch unit; sequential fetches into a credit-limited buffer feeding the id stage.
// Define PFU_RSP_BYPASS_EN to forward a response straight to the id stage when the buffer is empty.
module pfu
   import pfu_pkg::*;
#(
   parameter int          DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clk_en_i,
   output logic        ids_dav_o,
   input  logic        ids_ack_i,
   output sofid_t      ids_sofid_o,
   output logic [31:0] ids_ins_o,
   output logic        ids_ferr_o,
   output logic [31:0] ids_pc_o,
   input  logic        exs_pc_wr_i,
   input  logic [31:0] exs_pc_din_i,
   output logic        ireqvalid_o,
   input  logic        ireqready_i,
   output logic [31:0] ireqaddr_o,
   input  logic        irspvalid_i,
   output logic        irspready_o,
   input  logic        irsprerr_i,
   input  logic [31:0] irspdata_i
);
   localparam int               CNT_W      = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      fetch_addr_q, rsp_pc_q, vec_addr;
   logic [CNT_W-1:0] outstanding_q, outstanding_d, drop_q, fifo_count;
   logic             sof_pend_q, vector, req_fire, rsp_keep, bypass_avail;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   fetch_entry_t     rsp_entry, fifo_head, head;

   assign vector      = exs_pc_wr_i;
   assign vec_addr    = exs_pc_din_i & 32'hFFFF_FFFC;
   assign ireqvalid_o = clk_en_i & ~reset_i & (state_q == ST_RUN) & ~vector &
                        (({1'b0, fifo_count} + {1'b0, outstanding_q}) < CREDIT_MAX);
   assign ireqaddr_o  = fetch_addr_q;
   assign req_fire    = ireqvalid_o & ireqready_i;
   assign irspready_o = 1'b1;

   // Responses issued before the last vector are dropped; rsp_pc_q tracks the next kept word's address.
   assign rsp_keep  = irspvalid_i & (drop_q == '0) & ~vector;
   assign rsp_entry = '{ins: irspdata_i, pc: rsp_pc_q, ferr: irsprerr_i,
                        sofid: sof_pend_q ? SOFID_FIRST : SOFID_NEXT};

`ifdef PFU_RSP_BYPASS_EN
   assign bypass_avail = rsp_keep & fifo_empty;
   assign head         = bypass_avail ? rsp_entry : fifo_head;
`else
   assign bypass_avail = 1'b0;
   assign head         = fifo_head;
`endif

   assign ids_dav_o   = ~reset_i & ~vector & (~fifo_empty | bypass_avail);
   assign ids_ins_o   = head.ins;
   assign ids_pc_o    = head.pc;
   assign ids_ferr_o  = head.ferr;
   assign ids_sofid_o = head.sofid;

   assign fifo_pop  = ids_dav_o & ids_ack_i & ~fifo_empty;
   assign fifo_push = rsp_keep & ~fifo_full & ~(bypass_avail & ids_ack_i);

   pfu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (clk_en_i),
      .flush_i (vector),
      .push_i  (fifo_push),
      .din_i   (rsp_entry),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d       = state_q;
      outstanding_d = outstanding_q;
      if (vector)                      state_d = ST_RUN;
      else if (rsp_keep && irsprerr_i) state_d = ST_HALT;
      if (req_fire)    outstanding_d = outstanding_d + CNT_ONE;
      if (irspvalid_i) outstanding_d = outstanding_d - CNT_ONE;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)       state_q <= ST_RUN;
      else if (clk_en_i) state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fetch_addr_q  <= RESET_ADDR;
         rsp_pc_q      <= RESET_ADDR;
         outstanding_q <= '0;
         drop_q        <= '0;
         sof_pend_q    <= 1'b1;
      end else if (clk_en_i) begin
         outstanding_q <= outstanding_d;
         if (vector) begin
            fetch_addr_q <= vec_addr;
            rsp_pc_q     <= vec_addr;
            drop_q       <= irspvalid_i ? outstanding_q - CNT_ONE : outstanding_q;
            sof_pend_q   <= 1'b1;
         end else begin
            if (req_fire) fetch_addr_q <= fetch_addr_q + 32'd4;
            if (irspvalid_i && drop_q != '0) drop_q <= drop_q - CNT_ONE;
            if (rsp_keep) begin
               rsp_pc_q   <= rsp_pc_q + 32'd4;
               sof_pend_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pfu.sv
// tb_pfu: directed scenarios for pfu with a bus model, an expected-word queue and a delivery monitor.
module tb_pfu;
   import pfu_pkg::*;

   localparam int          DEPTH      = 4;
   localparam logic [31:0] RESET_ADDR = 32'h0000_0100;

   logic        clk_i = 1'b0;
   logic        reset_i, clk_en_i;
   logic        ids_dav_o, ids_ack_i, ids_ferr_o;
   sofid_t      ids_sofid_o;
   logic [31:0] ids_ins_o, ids_pc_o;
   logic        exs_pc_wr_i;
   logic [31:0] exs_pc_din_i;
   logic        ireqvalid_o, ireqready_i, irspvalid_i, irspready_o, irsprerr_i;
   logic [31:0] ireqaddr_o, irspdata_i;

   always #5 clk_i = ~clk_i;

   pfu #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .clk_en_i     (clk_en_i),
      .ids_dav_o    (ids_dav_o),
      .ids_ack_i    (ids_ack_i),
      .ids_sofid_o  (ids_sofid_o),
      .ids_ins_o    (ids_ins_o),
      .ids_ferr_o   (ids_ferr_o),
      .ids_pc_o     (ids_pc_o),
      .exs_pc_wr_i  (exs_pc_wr_i),
      .exs_pc_din_i (exs_pc_din_i),
      .ireqvalid_o  (ireqvalid_o),
      .ireqready_i  (ireqready_i),
      .ireqaddr_o   (ireqaddr_o),
      .irspvalid_i  (irspvalid_i),
      .irspready_o  (irspready_o),
      .irsprerr_i   (irsprerr_i),
      .irspdata_i   (irspdata_i)
   );

   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } pend_t;

   pend_t        pend_q[$];
   fetch_entry_t exp_q[$];
   int           n_vec = 0, n_bad = 0, n_req = 0, n_deliv = 0;
   logic [31:0]  exp_req = RESET_ADDR;
   bit           exp_sof = 1'b1;
   bit           ack_en, ready_en, rsp_en, vec_now, rst_now, en_now, err_armed;
   logic [31:0]  vec_tgt, err_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One bus/id cycle: drive at the falling edge, observe request handshakes 1 ns later.
   task automatic tick();
      pend_t        p;
      fetch_entry_t e;
      @(negedge clk_i);
      reset_i      = rst_now;
      clk_en_i     = en_now;
      ids_ack_i    = ack_en;
      ireqready_i  = ready_en;
      exs_pc_wr_i  = vec_now;
      exs_pc_din_i = vec_tgt;
      irspvalid_i  = 1'b0;
      irsprerr_i   = 1'b0;
      irspdata_i   = '0;
      if (rst_now) begin
         pend_q.delete();
         exp_q.delete();
         exp_sof = 1'b1;
         exp_req = RESET_ADDR;
      end else if (en_now) begin
         if (rsp_en && pend_q.size() > 0) begin
            p           = pend_q.pop_front();
            irspvalid_i = 1'b1;
            irspdata_i  = mem_word(p.addr);
            irsprerr_i  = err_armed && (p.addr == err_addr);
            if (!p.stale && !vec_now) begin
               e.ins   = irspdata_i;
               e.pc    = p.addr;
               e.ferr  = irsprerr_i;
               e.sofid = exp_sof ? SOFID_FIRST : SOFID_NEXT;
               exp_sof = 1'b0;
               exp_q.push_back(e);
            end
         end
         if (vec_now) begin
            for (int i = 0; i < pend_q.size(); i++) pend_q[i].stale = 1'b1;
            exp_q.delete();
            exp_sof = 1'b1;
            exp_req = vec_tgt & 32'hFFFF_FFFC;
         end
      end
      #1;
      if (!rst_now && !en_now) check("req_while_disabled", ireqvalid_o, 1'b0);
      if (!rst_now && en_now && vec_now) check("req_in_vector_cycle", ireqvalid_o, 1'b0);
      if (!rst_now && en_now && ireqvalid_o && ireqready_i) begin
         check("req_addr", ireqaddr_o, exp_req);
         p.addr  = ireqaddr_o;
         p.stale = 1'b0;
         pend_q.push_back(p);
         exp_req = exp_req + 32'd4;
         n_req++;
      end
      vec_now = 1'b0;
   endtask

   task automatic do_reset();
      rst_now = 1'b1;
      en_now  = 1'b1;
      repeat (2) tick();
      check("rst_dav", ids_dav_o, 1'b0);
      check("rst_reqvalid", ireqvalid_o, 1'b0);
      check("rst_rspready", irspready_o, 1'b1);
      rst_now = 1'b0;
   endtask

   task automatic drain(input string name);
      ready_en = 1'b0;
      rsp_en   = 1'b1;
      ack_en   = 1'b1;
      repeat (10) tick();
      check(name, exp_q.size(), 0);
   endtask

   task automatic vector_to(input logic [31:0] tgt);
      vec_now = 1'b1;
      vec_tgt = tgt;
      tick();
   endtask

   // Delivery monitor: every accepted word must match the oldest expected entry.
   always @(negedge clk_i) begin
      fetch_entry_t e;
      #2;
      if (!reset_i && clk_en_i && ids_dav_o && ids_ack_i) begin
         n_deliv++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_delivery: pc %h delivered, nothing expected", ids_pc_o);
         end else begin
            e = exp_q.pop_front();
            check("ids_pc", ids_pc_o, e.pc);
            check("ids_ins", ids_ins_o, e.ins);
            check("ids_ferr", ids_ferr_o, e.ferr);
            check("ids_sofid", ids_sofid_o, e.sofid);
         end
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      int r0, d0;
      logic s_dav;
      logic [31:0] s_pc;
      reset_i = 1'b1; clk_en_i = 1'b1; ids_ack_i = 1'b0; ireqready_i = 1'b0;
      exs_pc_wr_i = 1'b0; exs_pc_din_i = '0; irspvalid_i = 1'b0; irsprerr_i = 1'b0; irspdata_i = '0;
      vec_now = 1'b0; vec_tgt = '0; err_armed = 1'b0; err_addr = 32'h0000_0108;

      // Streaming: first request right after reset, then one word per cycle.
      ack_en = 1'b1; ready_en = 1'b1; rsp_en = 1'b1;
      do_reset();
      r0 = n_req;
      tick();
      check("first_req_after_reset", n_req - r0, 1);
      repeat (4) tick();
      d0 = n_deliv;
      repeat (10) tick();
      check("throughput_10_cycles", n_deliv - d0, 10);
      drain("drain_stream");

      // id stage stalls: credits stop at DEPTH requests.
      ack_en = 1'b0; ready_en = 1'b1; rsp_en = 1'b1;
      do_reset();
      r0 = n_req;
      repeat (12) tick();
      check("stall_req_count", n_req - r0, 4);
      check("stall_dav", ids_dav_o, 1'b1);
      check("stall_reqvalid", ireqvalid_o, 1'b0);
      ack_en = 1'b1;
      repeat (6) tick();
      drain("drain_stall");

      // Vector with three requests outstanding: their responses are discarded.
      ack_en = 1'b1; ready_en = 1'b1; rsp_en = 1'b0;
      do_reset();
      r0 = n_req;
      for (int i = 0; i < 10 && (n_req - r0) < 3; i++) tick();
      ready_en = 1'b0;
      check("outstanding_before_vector", n_req - r0, 3);
      tick();
      rsp_en = 1'b1; ready_en = 1'b1;
      vector_to(32'h0000_2002);
      r0 = n_req;
      tick();
      check("req_after_vector", n_req - r0, 1);
      d0 = n_deliv;
      repeat (8) tick();
      check("delivered_after_vector", (n_deliv - d0) > 0, 1'b1);
      drain("drain_vector");

      // Bus error at 0x108 halts fetching until a vector to 0x400.
      err_armed = 1'b1;
      ack_en = 1'b1; ready_en = 1'b1; rsp_en = 1'b1;
      do_reset();
      r0 = n_req;
      repeat (10) tick();
      check("halt_req_count", n_req - r0, 4);
      check("halt_dav_empty", ids_dav_o, 1'b0);
      vector_to(32'h0000_0400);
      r0 = n_req;
      tick();
      check("resume_after_error", n_req - r0, 1);
      repeat (6) tick();
      drain("drain_error");
      err_armed = 1'b0;

      // Push and pop in the same cycle with two words buffered.
      ack_en = 1'b0; ready_en = 1'b1; rsp_en = 1'b1;
      do_reset();
      r0 = n_req;
      for (int i = 0; i < 10 && (n_req - r0) < 2; i++) tick();
      ready_en = 1'b0;
      repeat (3) tick();
      check("two_buffered_dav", ids_dav_o, 1'b1);
      ready_en = 1'b1;
      tick();
      ack_en = 1'b1;
      repeat (6) tick();

      // Vector coinciding with an ack: the buffer empties and the ack is ignored.
      ack_en = 1'b0;
      repeat (6) tick();
      check("full_before_vector_dav", ids_dav_o, 1'b1);
      ack_en = 1'b1;
      vector_to(32'h0000_3000);
      tick();
      check("dav_after_vector_flush", ids_dav_o, 1'b0);
      repeat (4) tick();

      // Address wraps past 0xFFFFFFFC, then the clock enable freezes everything.
      vector_to(32'hFFFF_FFFC);
      repeat (6) tick();
      rsp_en = 1'b0;
      en_now = 1'b0;
      tick();
      r0    = n_req;
      s_dav = ids_dav_o;
      s_pc  = ids_pc_o;
      repeat (4) tick();
      check("clk_en_req_count", n_req - r0, 0);
      check("clk_en_dav_stable", ids_dav_o, s_dav);
      check("clk_en_pc_stable", ids_pc_o, s_pc);
      en_now = 1'b1; rsp_en = 1'b1;
      repeat (6) tick();
      drain("drain_wrap");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pfu.md
# pfu

Prefetch unit for the rv32i core: issues sequential 32-bit instruction fetches on the instruction memory bus, buffers returned words in a small FIFO, and presents them to the id stage through the dav/ack fetch interface (dav, ack, sofid, ins, ferr, pc). It is the producer end of the id stage's fetch interface. On a vector request from the ex stage it flushes, discards in-flight responses, and restarts at the new address, tagging the first delivered word as start-of-fetch.

## Interface
- DEPTH, 4: fetch buffer entries and maximum fetch credits; power of 2, ≥2.
- RESET_ADDR, 32'h0000_0000: first fetch address after reset.
- clk_i  in  1  sole clock, rising edge.
- reset_i  in  1  reset, synchronous and active-high; overrides clk_en_i.
- clk_en_i  in  1  global clock enable; when low, no state changes.
- ids_dav_o  out  1  fetch available to id stage.
- ids_ack_i  in  1  id stage consumes head entry; only honoured while ids_dav_o=1.
- ids_sofid_o  out  `SOFID_RANGE  `SOFID_1ST for first word after reset/vector, else `SOFID_RUN.
- ids_ins_o  out  32  instruction word.
- ids_ferr_o  out  1  head word's fetch returned a bus error.
- ids_pc_o  out  32  address of head word.
- exs_pc_wr_i  in  1  vector request (jump/branch taken/trap).
- exs_pc_din_i  in  32  vector target; bits [1:0] ignored (treated as 0).
- ireqvalid_o  out  1  fetch request valid.
- ireqready_i  in  1  bus accepts request.
- ireqaddr_o  out  32  fetch address, word aligned.
- irspvalid_i  in  1  response valid; in request order.
- irspready_o  out  1  constant 1 (space guaranteed by credits).
- irsprerr_i  in  1  response bus error.
- irspdata_i  in  32  response data.

## Operation
- State: fetch_addr_q, outstanding_q (0..DEPTH), drop_q (0..DEPTH), FIFO count, sof_pend_q, FSM {RUN, HALT}.
- Request: ireqvalid_o = RUN & ~exs_pc_wr_i & (count + outstanding_q < DEPTH). Handshake on ireqvalid_o & ireqready_i: fetch_addr_q += 4 (mod 2^32, wraps), outstanding_q += 1.
- Response: each irspvalid_i decrements outstanding_q. If drop_q>0 or exs_pc_wr_i: discarded, drop_q -= 1 when nonzero. Else pushed as {data, err, pc, sofid}; pc comes from a per-entry address tracker (issued address order), sofid=`SOFID_1ST if sof_pend_q then sof_pend_q cleared.
- Fetch error: pushed with ferr=1; FSM RUN->HALT (no further requests). HALT->RUN only on vector.
- Delivery: ids_dav_o = FIFO nonempty & ~exs_pc_wr_i; pop on ids_dav_o & ids_ack_i. Push and pop in same cycle: count unchanged.
- Vector (exs_pc_wr_i, clk_en_i): FIFO flushed; fetch_addr_q <= {din[31:2],2'b00}; drop_q <= outstanding_q minus any response this cycle; sof_pend_q <= 1; FSM <= RUN. Vector overrides ack, push and error in the same cycle.
- Reset: fetch_addr_q=RESET_ADDR, counts 0, drop_q 0, sof_pend_q=1, RUN. Outputs during/after reset: ids_dav_o=0, ireqvalid_o=0 while reset_i high, irspready_o=1; data outputs don't-care while ids_dav_o=0. Reset mid-transaction: in-flight responses are undefined-bus; system resets the bus concurrently.

## Timing
- First request: cycle after reset_i deasserts, address RESET_ADDR.
- Vector: ireqvalid_o low in vector cycle; first request to target on next cycle.
- Response to ids_dav_o: 1 cycle (registered FIFO) without bypass.
- Sustained throughput: 1 word/cycle with single-cycle bus and DEPTH≥2.
- ids_dav_o/ids_* stable until acked or vectored.

## Configuration
- PFU_RSP_BYPASS_EN defined: when FIFO empty, drop_q=0, no vector, a response is presented on ids_* combinationally in its arrival cycle; if acked it is not written to the FIFO. Latency 0 cycles.
- Undefined: all responses pass through FIFO; latency 1 cycle; no combinational path from bus to id stage.

## Structure
- `SOFID_RANGE, `SOFID_1ST, `SOFID_RUN in riscv_defs.v (shared); FSM state encodings local.
- One sub-module: pfu_fifo (DEPTH x {32 ins, 32 pc, 1 ferr, sofid}), sync flush, push/pop/count, full/empty.

## Test plan
- Reset, RESET_ADDR=0x100, bus always ready, 1-cycle response, id always acks -> requests 0x100,0x104,...; first ids word sofid=1ST pc=0x100, then RUN, 1 word/cycle.
- id never acks, DEPTH=4 -> exactly 4 requests issued, ireqvalid_o stays 0, FIFO full, no overflow.
- 3 requests outstanding, vector to 0x2002 -> 3 returning responses discarded, next request 0x2000, first delivered pc=0x2000 sofid=1ST.
- Response with irsprerr_i at 0x108 -> delivered ferr=1 pc=0x108, no requests after, until vector to 0x400 resumes fetch at 0x400.
- Push and ack same cycle at count=2 -> count stays 2, order preserved; vector same cycle as ack -> FIFO empty next cycle, ack ignored.
- fetch_addr 0xFFFFFFFC -> next request 0x00000000; clk_en_i low 5 cycles -> no state change, no new requests counted.
